// File: rtl/i2c_ack_monitor.sv
// I2C write-frame ACK monitor: samples SDA once per bit slot, checks readback against the
// driven address/data bits, and reports per-frame pass/fail plus retry/give-up state.
module i2c_ack_monitor #(
  parameter logic [6:0]  I2C_ADDR  = 7'h78,
  parameter int unsigned FRAME_END = 43,
  parameter int unsigned MAX_RETRY = 3,
  parameter int unsigned ERR_CNT_W = 8
) (
  input  logic                 ack_clk,
  input  logic                 reset,
  input  logic                 i_active,
  input  logic [5:0]           i_bit_index,
  input  logic                 i_sda_in,
  input  logic [23:0]          i_exp_dat,
  input  logic                 i_clear_err,
  output logic                 o_frame_ok,
  output logic                 o_frame_nack,
  output logic [3:0]           o_nack_mask,
  output logic                 o_bus_err,
  output logic                 o_retry_req,
  output logic [1:0]           o_retry_count,
  output logic                 o_give_up,
  output logic [ERR_CNT_W-1:0] o_err_count,
  output logic                 o_aborted
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SAMPLE = 2'd1,
    ST_REPORT = 2'd2
  } state_t;

  localparam logic [5:0]           END_IDX   = 6'(FRAME_END);
  localparam logic [1:0]           RETRY_MAX = 2'(MAX_RETRY);
  localparam logic [ERR_CNT_W-1:0] ERR_SAT   = {ERR_CNT_W{1'b1}};

  state_t      r_state;
  logic [3:0]  r_nack_acc;
  logic        r_mismatch;

  logic        w_cmp;
  logic        w_exp_bit;
  logic        w_miss;
  logic        w_fail;

  // Which bit the master drove in the current slot; ACK slots and gaps are not compared.
  always_comb begin
    w_cmp     = 1'b0;
    w_exp_bit = 1'b0;
    if (i_bit_index >= 6'd4 && i_bit_index <= 6'd10) begin
      w_cmp     = 1'b1;
      w_exp_bit = I2C_ADDR[3'(6'd10 - i_bit_index)];
    end else if (i_bit_index == 6'd11) begin
      w_cmp     = 1'b1;
      w_exp_bit = 1'b0;
    end else if (i_bit_index >= 6'd13 && i_bit_index <= 6'd20) begin
      w_cmp     = 1'b1;
      w_exp_bit = i_exp_dat[5'(6'd36 - i_bit_index)];
    end else if (i_bit_index >= 6'd22 && i_bit_index <= 6'd29) begin
      w_cmp     = 1'b1;
      w_exp_bit = i_exp_dat[5'(6'd37 - i_bit_index)];
    end else if (i_bit_index >= 6'd31 && i_bit_index <= 6'd38) begin
      w_cmp     = 1'b1;
      w_exp_bit = i_exp_dat[5'(6'd38 - i_bit_index)];
    end
  end

  assign w_miss = w_cmp && (i_sda_in != w_exp_bit);
  assign w_fail = (r_nack_acc != 4'b0000) || r_mismatch;

  always_ff @(posedge ack_clk or posedge reset) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_nack_acc    <= 4'b0000;
      r_mismatch    <= 1'b0;
      o_frame_ok    <= 1'b0;
      o_frame_nack  <= 1'b0;
      o_nack_mask   <= 4'b0000;
      o_bus_err     <= 1'b0;
      o_retry_req   <= 1'b0;
      o_retry_count <= 2'd0;
      o_give_up     <= 1'b0;
      o_err_count   <= '0;
      o_aborted     <= 1'b0;
    end else begin
      o_frame_ok   <= 1'b0;
      o_frame_nack <= 1'b0;
      o_aborted    <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (i_active && i_bit_index == 6'd4) begin
            r_state     <= ST_SAMPLE;
            r_nack_acc  <= 4'b0000;
            r_mismatch  <= w_miss;
            o_retry_req <= 1'b0;
          end
        end

        ST_SAMPLE: begin
          if (!i_active) begin
            r_state   <= ST_IDLE;
            o_aborted <= 1'b1;
          end else if (i_bit_index == END_IDX) begin
            r_state     <= ST_REPORT;
            o_nack_mask <= r_nack_acc;
            o_bus_err   <= r_mismatch;
            if (!w_fail) begin
              o_frame_ok    <= 1'b1;
              o_retry_count <= 2'd0;
            end else begin
              o_frame_nack <= 1'b1;
              if (o_err_count != ERR_SAT) begin
                o_err_count <= o_err_count + ERR_CNT_W'(1);
              end
              if (o_retry_count < RETRY_MAX) begin
                o_retry_req   <= 1'b1;
                o_retry_count <= o_retry_count + 2'd1;
              end else begin
                o_give_up   <= 1'b1;
                o_retry_req <= 1'b0;
              end
            end
          end else begin
            if (w_miss) begin
              r_mismatch <= 1'b1;
            end
            case (i_bit_index)
              6'd12:   r_nack_acc[0] <= i_sda_in;
              6'd21:   r_nack_acc[1] <= i_sda_in;
              6'd30:   r_nack_acc[2] <= i_sda_in;
              6'd39:   r_nack_acc[3] <= i_sda_in;
              default: ;
            endcase
          end
        end

        ST_REPORT: r_state <= ST_IDLE;

        default: r_state <= ST_IDLE;
      endcase

      // Error clear overrides any same-edge report update of these four.
      if (i_clear_err) begin
        o_err_count   <= '0;
        o_retry_count <= 2'd0;
        o_retry_req   <= 1'b0;
        o_give_up     <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_i2c_ack_monitor.sv
// Scoreboard bench for i2c_ack_monitor: directed frames push expected reports,
// a negedge monitor pops and compares whenever a frame/abort pulse appears.
module tb_i2c_ack_monitor;

  logic        ack_clk;
  logic        reset;
  logic        i_active;
  logic [5:0]  i_bit_index;
  logic        i_sda_in;
  logic [23:0] i_exp_dat;
  logic        i_clear_err;
  logic        o_frame_ok;
  logic        o_frame_nack;
  logic [3:0]  o_nack_mask;
  logic        o_bus_err;
  logic        o_retry_req;
  logic [1:0]  o_retry_count;
  logic        o_give_up;
  logic [7:0]  o_err_count;
  logic        o_aborted;

  i2c_ack_monitor dut (
    .ack_clk       (ack_clk),
    .reset         (reset),
    .i_active      (i_active),
    .i_bit_index   (i_bit_index),
    .i_sda_in      (i_sda_in),
    .i_exp_dat     (i_exp_dat),
    .i_clear_err   (i_clear_err),
    .o_frame_ok    (o_frame_ok),
    .o_frame_nack  (o_frame_nack),
    .o_nack_mask   (o_nack_mask),
    .o_bus_err     (o_bus_err),
    .o_retry_req   (o_retry_req),
    .o_retry_count (o_retry_count),
    .o_give_up     (o_give_up),
    .o_err_count   (o_err_count),
    .o_aborted     (o_aborted)
  );

  initial ack_clk = 1'b0;
  always #5 ack_clk = ~ack_clk;

  // Packed view {ok, nack, aborted, mask[3:0], bus_err, retry_req, retry_count[1:0], give_up, err[7:0]}
  typedef struct {
    string       name;
    logic [19:0] v;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  logic        m_rr;
  logic [1:0]  m_rc;
  logic        m_gu;
  logic [7:0]  m_err;
  logic [3:0]  m_mask;
  logic        m_bus;

  wire [19:0] w_act = {o_frame_ok, o_frame_nack, o_aborted, o_nack_mask, o_bus_err,
                       o_retry_req, o_retry_count, o_give_up, o_err_count};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [19:0] pack(input logic ok, input logic nk, input logic ab);
    return {ok, nk, ab, m_mask, m_bus, m_rr, m_rc, m_gu, m_err};
  endfunction

  task automatic tick();
    @(posedge ack_clk);
    #1;
  endtask

  task automatic model_reset();
    m_rr = 1'b0; m_rc = 2'd0; m_gu = 1'b0; m_err = 8'd0; m_mask = 4'd0; m_bus = 1'b0;
  endtask

  task automatic idle_inputs();
    i_active = 1'b0; i_bit_index = 6'd0; i_sda_in = 1'b1; i_clear_err = 1'b0;
  endtask

  // One full write frame; nack_idx/flip_idx/abort_idx < 0 mean "none".
  task automatic run_frame(input string name, input logic [23:0] d, input int nack_idx,
                           input int flip_idx, input int abort_idx, input bit clr_end,
                           input bit chk_rr_clear);
    logic [39:0] fb;
    logic [5:0]  pos;
    logic        fail;
    exp_t        e;
    fb = {4'b0000, 7'h78, 1'b0, 1'b0, d[23:16], 1'b0, d[15:8], 1'b0, d[7:0], 1'b0};
    i_exp_dat = d;
    m_rr = 1'b0;
    for (int idx = 4; idx <= 43; idx++) begin
      pos = 6'(39 - idx);
      i_active    = (idx != abort_idx);
      i_bit_index = 6'(idx);
      i_sda_in    = (idx <= 39) ? fb[pos] : 1'b0;
      if (idx == nack_idx) i_sda_in = 1'b1;
      if (idx == flip_idx) i_sda_in = ~i_sda_in;
      i_clear_err = clr_end && (idx == 43);
      if (idx == abort_idx) begin
        e.name = {name, "_abort"};
        e.v    = pack(1'b0, 1'b0, 1'b1);
        sb_q.push_back(e);
        tick();
        break;
      end
      if (idx == 43) begin
        fail   = (nack_idx >= 0) || (flip_idx >= 0);
        m_mask = 4'd0;
        case (nack_idx)
          12: m_mask = 4'b0001;
          21: m_mask = 4'b0010;
          30: m_mask = 4'b0100;
          39: m_mask = 4'b1000;
          default: ;
        endcase
        m_bus = (flip_idx >= 0);
        if (!fail) begin
          m_rc = 2'd0;
        end else begin
          if (m_err != 8'hFF) m_err = m_err + 8'd1;
          if (m_rc < 2'd3) begin
            m_rr = 1'b1;
            m_rc = m_rc + 2'd1;
          end else begin
            m_gu = 1'b1;
            m_rr = 1'b0;
          end
        end
        if (clr_end) begin
          m_err = 8'd0; m_rc = 2'd0; m_rr = 1'b0; m_gu = 1'b0;
        end
        e.name = name;
        e.v    = pack(!fail, fail, 1'b0);
        sb_q.push_back(e);
      end
      tick();
      if (idx == 4 && chk_rr_clear) check({name, "_retry_req_cleared_at_start"}, 32'(o_retry_req), 32'd0);
    end
    idle_inputs();
    tick();
    tick();
  endtask

  task automatic pulse_clear(input string name);
    i_clear_err = 1'b1;
    tick();
    i_clear_err = 1'b0;
    m_err = 8'd0; m_rc = 2'd0; m_rr = 1'b0; m_gu = 1'b0;
    check({name, "_err_count"},   32'(o_err_count),   32'd0);
    check({name, "_give_up"},     32'(o_give_up),     32'd0);
    check({name, "_retry_count"}, 32'(o_retry_count), 32'd0);
  endtask

  // Scoreboard monitor: any report/abort pulse must match the oldest expectation.
  always @(negedge ack_clk) begin
    exp_t e;
    if (!reset && (o_frame_ok || o_frame_nack || o_aborted)) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_pulse: actual=0x%05h expected=no pulse", w_act);
      end else begin
        e = sb_q.pop_front();
        n_checks++;
        if (w_act !== e.v) begin
          n_fail++;
          $display("FAIL %s: actual=0x%05h expected=0x%05h", e.name, w_act, e.v);
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    i_exp_dat = 24'h0;
    idle_inputs();
    model_reset();
    repeat (3) tick();
    check("reset_outputs", 32'(w_act), 32'd0);
    #2 reset = 1'b0;
    tick();

    run_frame("clean", 24'h300882, -1, -1, -1, 1'b0, 1'b0);
    run_frame("nack21", 24'h300882, 21, -1, -1, 1'b0, 1'b0);
    check("retry_req_held_idle", 32'(o_retry_req), 32'd1);
    run_frame("clean_after_nack", 24'h300882, -1, -1, -1, 1'b0, 1'b1);

    pulse_clear("clear1");
    for (int k = 0; k < 4; k++) run_frame($sformatf("nack12_%0d", k), 24'h300882, 12, -1, -1, 1'b0, 1'b0);
    run_frame("good_while_give_up", 24'h3008A5, -1, -1, -1, 1'b0, 1'b0);
    check("give_up_sticky", 32'(o_give_up), 32'd1);
    pulse_clear("clear2");

    run_frame("bus_err15", 24'h300882, -1, 15, -1, 1'b0, 1'b0);
    run_frame("abort25", 24'h300882, -1, -1, 25, 1'b0, 1'b0);
    check("abort_keeps_err", 32'(o_err_count), 32'd1);
    run_frame("after_abort", 24'h123456, 30, -1, -1, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a frame.
    i_exp_dat = 24'h300882;
    for (int idx = 4; idx <= 20; idx++) begin
      i_active = 1'b1; i_bit_index = 6'(idx); i_sda_in = 1'b0;
      tick();
    end
    #2 reset = 1'b1;
    #1 check("async_reset_mid_frame", 32'(w_act), 32'd0);
    idle_inputs();
    model_reset();
    tick();
    #2 reset = 1'b0;
    tick();

    for (int k = 0; k < 255; k++) run_frame("sat_fill", 24'h300882, 39, -1, -1, 1'b0, 1'b0);
    check("err_count_at_255", 32'(o_err_count), 32'd255);
    run_frame("sat_hold", 24'h300882, 12, -1, -1, 1'b0, 1'b0);
    check("err_count_saturated", 32'(o_err_count), 32'd255);
    run_frame("clear_on_report", 24'h300882, 12, -1, -1, 1'b1, 1'b0);

    repeat (4) tick();
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
